main_divider: RTL and testbench

- Sequential unsigned fixed-point divider for 10-bit Q4.6 operands: 4 integer bits, 6 fraction bits.
- Computes q_out = a_in / b_in in Q4.6, truncating toward zero.
- Flags divide-by-zero and quotient overflow.
- Uses a start/busy/valid handshake and sits as a standalone arithmetic unit driven by a controller.

---
 rtl/main_divider.sv | 172 +++++++++++++++++
 tb/tb_main_divider.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/main_divider.sv
// main_divider: sequential unsigned Q4.6 / Q4.6 restoring divider.
//
// Handshake: a request is accepted on a rising edge where start=1 and the
// unit is idle (busy=0); the operands are captured on that edge only. busy is
// high while the iterative core runs. valid is high when q_out, dvz and ovf
// hold a completed result. These outputs keep their values until the next
// accepted request or sclr. start while busy is ignored. Divide-by-zero and
// overflow are resolved on the accepting edge, so busy never rises for them.
module main_divider (
  input  logic       clk,
  input  logic       sclr,
  input  logic [9:0] a_in,
  input  logic [9:0] b_in,
  input  logic       start,
  output logic [9:0] q_out,
  output logic       dvz,
  output logic       ovf,
  output logic       busy,
  output logic       valid,
  output logic       dbg_state
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CALC = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] dividend_q, dividend_d;
  logic [9:0]  divisor_q, divisor_d;
  logic [9:0]  rem_q, rem_d;
  logic [9:0]  quot_q, quot_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  q_out_q, q_out_d;
  logic        dvz_q, dvz_d;
  logic        ovf_q, ovf_d;
  logic        valid_q, valid_d;

  // Per-step datapath values. The shifted remainder is 11 bits wide so the
  // trial subtraction keeps its carry; the borrow lands in trial[11].
  logic [10:0] rem_shift;
  logic [11:0] trial;
  logic        q_bit;
  logic        last_step;
  logic        is_zero;
  logic        is_ovf;

  // Operand classification on the accepting edge: quotient >= 16.0 when
  // a >= 16*b, which cannot be represented in Q4.6.
  always_comb begin
    is_zero = (b_in == 10'd0);
    is_ovf  = ({4'b0000, a_in} >= {b_in, 4'b0000});
  end

  // One restoring-division step. The upper six quotient bits are always zero
  // once overflow has been excluded, so only the low ten bits are kept.
  always_comb begin
    rem_shift = {rem_q, dividend_q[15]};
    trial     = {1'b0, rem_shift} - {2'b00, divisor_q};
    q_bit     = ~trial[11];
    last_step = (cnt_q == 4'd15);
  end

  // State register plus all datapath/result flops; sclr wins over everything.
  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q    <= S_IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      cnt_q      <= '0;
      q_out_q    <= '0;
      dvz_q      <= 1'b0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      cnt_q      <= cnt_d;
      q_out_q    <= q_out_d;
      dvz_q      <= dvz_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
    end
  end

  // Next-state logic: enter CALC only for a representable, non-zero-divisor
  // request; leave after the sixteenth step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start && !is_zero && !is_ovf) begin
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (last_step) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and result register updates for each state.
  always_comb begin
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    cnt_d      = cnt_q;
    q_out_d    = q_out_q;
    dvz_d      = dvz_q;
    ovf_d      = ovf_q;
    valid_d    = valid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          q_out_d = 10'd0;
          if (is_zero) begin
            dvz_d   = 1'b1;
            ovf_d   = 1'b0;
            valid_d = 1'b1;
          end else if (is_ovf) begin
            dvz_d   = 1'b0;
            ovf_d   = 1'b1;
            valid_d = 1'b1;
          end else begin
            dvz_d      = 1'b0;
            ovf_d      = 1'b0;
            valid_d    = 1'b0;
            dividend_d = {a_in, 6'b000000};
            divisor_d  = b_in;
            rem_d      = 10'd0;
            quot_d     = 10'd0;
            cnt_d      = 4'd0;
          end
        end
      end
      S_CALC: begin
        dividend_d = {dividend_q[14:0], 1'b0};
        // A kept remainder is always below the divisor, so ten bits suffice.
        rem_d      = q_bit ? trial[9:0] : rem_shift[9:0];
        quot_d     = {quot_q[8:0], q_bit};
        cnt_d      = cnt_q + 4'd1;
        if (last_step) begin
          q_out_d = {quot_q[8:0], q_bit};
          valid_d = 1'b1;
        end
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  // Output decode from the registered state and result flops.
  always_comb begin
    busy      = (state_q == S_CALC);
    dbg_state = state_q;
    q_out     = q_out_q;
    dvz       = dvz_q;
    ovf       = ovf_q;
    valid     = valid_q;
  end

endmodule

// File: tb/tb_main_divider.sv
// tb_main_divider: randomized and directed checks of main_divider against a
// plain-arithmetic model of Q4.6 division.
module tb_main_divider;

  logic       clk;
  logic       sclr;
  logic [9:0] a_in;
  logic [9:0] b_in;
  logic       start;
  logic [9:0] q_out;
  logic       dvz;
  logic       ovf;
  logic       busy;
  logic       valid;
  logic       dbg_state;

  int n_cmp;
  int n_err;

  // Expected results: {ovf, dvz, q[9:0]}
  logic [11:0] exp_q[$];

  main_divider dut (
    .clk       (clk),
    .sclr      (sclr),
    .a_in      (a_in),
    .b_in      (b_in),
    .start     (start),
    .q_out     (q_out),
    .dvz       (dvz),
    .ovf       (ovf),
    .busy      (busy),
    .valid     (valid),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, need completion)");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: floor(a*64/b), with divide-by-zero and >=16.0 overflow.
  function automatic logic [11:0] model(input logic [9:0] a, input logic [9:0] b);
    int unsigned q;
    if (b == 0) return {1'b0, 1'b1, 10'd0};
    q = (int'(a) * 64) / int'(b);
    if (q >= 1024) return {1'b1, 1'b0, 10'd0};
    return {2'b00, q[9:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int cycles);
    @(negedge clk);
    sclr  = 1'b1;
    start = 1'b0;
    repeat (cycles) @(negedge clk);
    sclr = 1'b0;
  endtask

  // Issue one request and check the whole transaction, scrambling start and
  // operands while busy to show they are ignored.
  task automatic run_op(input logic [9:0] a, input logic [9:0] b, input string tag);
    logic [11:0] e;
    int n;
    logic [9:0] q_seen;
    exp_q.push_back(model(a, b));
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e = exp_q.pop_front();
    if (e[11] || e[10]) begin
      check_val({tag, "_fast_busy"}, 32'(busy), 32'd0);
    end else begin
      check_val({tag, "_busy_rise"}, 32'(busy), 32'd1);
      check_val({tag, "_valid_low"}, 32'(valid), 32'd0);
      n = 0;
      while (busy && n < 40) begin
        start = 1'($urandom_range(0, 1));
        a_in  = 10'($urandom);
        b_in  = 10'($urandom);
        @(negedge clk);
        n++;
      end
      start = 1'b0;
      check_val({tag, "_latency"}, 32'(n), 32'd16);
    end
    check_val({tag, "_valid"}, 32'(valid), 32'd1);
    check_val({tag, "_q"}, 32'(q_out), 32'(e[9:0]));
    check_val({tag, "_dvz"}, 32'(dvz), 32'(e[10]));
    check_val({tag, "_ovf"}, 32'(ovf), 32'(e[11]));
    q_seen = q_out;
    @(negedge clk);
    check_val({tag, "_hold_valid"}, 32'(valid), 32'd1);
    check_val({tag, "_hold_q"}, 32'(q_out), 32'(q_seen));
  endtask

  task automatic check_cleared(input string tag);
    check_val({tag, "_q"}, 32'(q_out), 32'd0);
    check_val({tag, "_dvz"}, 32'(dvz), 32'd0);
    check_val({tag, "_ovf"}, 32'(ovf), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_valid"}, 32'(valid), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [9:0] ra;
    logic [9:0] rb;
    int last_pulse;
    int pulses;
    int vhigh;
    logic [11:0] e;
    n_cmp = 0;
    n_err = 0;
    sclr  = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;

    do_reset(2);
    check_cleared("reset");

    // Directed vectors
    run_op(10'b1000001000, 10'b0001110100, "d_8p125");
    run_op(10'b0010000000, 10'b0001000000, "d_2div1");
    run_op(10'b0011111111, 10'b0000010000, "d_big");
    run_op(10'b1010101010, 10'b0000000000, "d_dvz");
    run_op(10'b0100000000, 10'b0000010000, "d_ovf16");
    run_op(10'b1111111111, 10'b0000000001, "d_ovfmax");
    run_op(10'b0011111111, 10'b0000010000, "d_below16");
    run_op(10'b0000000000, 10'b0000000111, "d_zero_a");

    // Random vectors, biased toward zero and small divisors
    for (int i = 0; i < 40; i++) begin
      ra = 10'($urandom);
      case ($urandom_range(0, 9))
        0:       rb = 10'd0;
        1, 2:    rb = 10'($urandom_range(1, 31));
        default: rb = 10'($urandom_range(1, 1023));
      endcase
      run_op(ra, rb, $sformatf("rnd%0d", i));
    end

    // Abort mid-operation with sclr
    @(negedge clk);
    a_in  = 10'b1000001000;
    b_in  = 10'b0001110100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0;
    check_cleared("abort");
    vhigh = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid || busy) vhigh++;
    end
    check_val("abort_no_result", 32'(vhigh), 32'd0);

    // start held high: one-cycle valid pulses every 17 cycles, same quotient
    e = model(10'b1000001000, 10'b0001110100);
    @(negedge clk);
    a_in  = 10'b1000001000;
    b_in  = 10'b0001110100;
    start = 1'b1;
    last_pulse = -1;
    pulses = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (valid) begin
        pulses++;
        check_val($sformatf("held_q%0d", pulses), 32'(q_out), 32'(e[9:0]));
        if (last_pulse >= 0) begin
          check_val($sformatf("held_period%0d", pulses), 32'(t - last_pulse), 32'd17);
        end
        last_pulse = t;
      end
    end
    check_val("held_pulses", 32'(pulses), 32'd3);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check_val("held_end_busy", 32'(busy), 32'd0);

    check_val("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
